// File: rtl/moxie_uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map,
// STATUS bit layout, transmit FSM encoding and the divisor sanitiser.
package moxie_uart_pkg;

    localparam logic [2:0] ADR_DATA   = 3'd0;
    localparam logic [2:0] ADR_STATUS = 3'd1;
    localparam logic [2:0] ADR_DIV    = 3'd2;
    localparam logic [2:0] ADR_CTRL   = 3'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // A zero divisor would make the bit period degenerate, so it becomes 1.
    function automatic logic [15:0] div_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/wb_uart_fifo.sv
// Synchronous byte FIFO with fall-through head; a push while full is only
// accepted when a pop happens in the same cycle.
module wb_uart_fifo
    import moxie_uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full_o    = (count_q == CNT_MAX);
    assign empty_o   = (count_q == {(AW + 1){1'b0}});
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | pop_i);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous reset; queued bytes are discarded.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave UART transmitter: DATA/STATUS/DIV/CTRL registers,
// TX FIFO and an 8N1 serialiser with a drained-FIFO level interrupt.
module wb_uart_tx
    import moxie_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_INIT   = 16'd867
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            ack_q;
    logic [15:0]     div_q, div_d;
    logic            irq_en_q, irq_en_d;
    logic            ovf_q, ovf_d;
    logic            irq_q, irq_d;
    tx_state_e       state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     div_act_q, div_act_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;

    logic            wr_s, push_req_s, pop_s, boundary_s, ovf_set_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [7:0]      fifo_rdata_s;
    logic [CW-1:0]   fifo_count_s;
    logic [15:0]     status_s, div_wr_s;

    assign wb_ack_o   = ack_q;
    assign tx_o       = tx_q;
    assign irq_o      = irq_q;
    assign wr_s       = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
    assign push_req_s = wr_s & (wb_adr_i == ADR_DATA) & wb_sel_i[0];
    assign ovf_set_s  = push_req_s & fifo_full_s & ~pop_s;
    assign boundary_s = (cnt_q == div_act_q);
    assign div_wr_s   = {wb_sel_i[1] ? wb_dat_i[15:8] : div_q[15:8],
                         wb_sel_i[0] ? wb_dat_i[7:0]  : div_q[7:0]};

    wb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_req_s),
        .wdata_i (wb_dat_i[7:0]),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // STATUS assembly and the read-data mux.
    always_comb begin
        status_s                   = 16'd0;
        status_s[ST_FULL]          = fifo_full_s;
        status_s[ST_EMPTY]         = fifo_empty_s;
        status_s[ST_BUSY]          = (state_q != S_IDLE);
        status_s[ST_OVF]           = ovf_q;
        status_s[ST_COUNT +: CW]   = fifo_count_s;
        wb_dat_o                   = 16'd0;
        if (!wb_we_i) begin
            case (wb_adr_i)
                ADR_STATUS: wb_dat_o = status_s;
                ADR_DIV:    wb_dat_o = div_q;
                ADR_CTRL:   wb_dat_o = {15'd0, irq_en_q};
                default:    wb_dat_o = 16'd0;
            endcase
        end else begin
            wb_dat_o = 16'd0;
        end
    end

    // Register-file updates; an overflow in the clearing cycle keeps OVF set.
    always_comb begin
        div_d    = div_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        if (wr_s && (wb_adr_i == ADR_DIV)) begin
            div_d = div_sanitize(div_wr_s);
        end else begin
            div_d = div_q;
        end
        if (wr_s && (wb_adr_i == ADR_CTRL) && wb_sel_i[0]) begin
            irq_en_d = wb_dat_i[0];
        end else begin
            irq_en_d = irq_en_q;
        end
        if (wr_s && (wb_adr_i == ADR_STATUS) && wb_sel_i[0] && wb_dat_i[ST_OVF]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end
        irq_d = irq_en_q & fifo_empty_s & (state_q == S_IDLE);
    end

    // Serialiser; each bit lasts div_act_q+1 clocks and DIV is resampled per bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        div_act_d = div_act_q;
        pop_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = 16'd0;
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    shreg_d   = fifo_rdata_s;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    div_act_d = div_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (boundary_s) begin
                    cnt_d     = 16'd0;
                    div_act_d = div_q;
                    state_d   = S_DATA;
                    bit_d     = 3'd0;
                    tx_d      = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (boundary_s) begin
                    cnt_d     = 16'd0;
                    div_act_d = div_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (boundary_s) begin
                    cnt_d     = 16'd0;
                    div_act_d = div_q;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shreg_d = fifo_rdata_s;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // All registered state; reset idles the line high immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q     <= 1'b0;
            div_q     <= DIV_INIT;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            div_act_q <= DIV_INIT;
            bit_q     <= 3'd0;
            shreg_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            ack_q     <= wb_cyc_i & wb_stb_i & ~ack_q;
            div_q     <= div_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: register vector table plus serial-line
// waveform sequences checked against hand-built expected bit streams.
module tb_wb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  adr = 3'd0;
    logic [15:0] dat_i = 16'd0;
    logic [15:0] dat_o;
    logic [1:0]  sel = 2'd0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        ack;
    logic        tx;
    logic        irq;

    int total = 0;
    int bad = 0;

    logic rec = 1'b0;
    logic txq[$];
    logic irqq[$];
    logic exp_q[$];

    typedef struct {
        logic        we;
        logic [2:0]  adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[21];

    wb_uart_tx dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_ack_o (ack),
        .tx_o     (tx),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec) begin
            txq.push_back(tx);
            irqq.push_back(irq);
        end
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [2:0] a, input logic [15:0] d,
                        input logic [1:0] s, output logic [15:0] rd);
        bit got = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        rd = dat_o;
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout: no ack within 8 cycles (adr %0d)", a);
        end else begin
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
        logic [15:0] unused_rd;
        xfer(1'b1, a, d, s, unused_rd);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] v;
        xfer(1'b0, a, 16'd0, 2'b11, v);
        check16(name, v, exp);
    endtask

    task automatic add_bits(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] b, input int per);
        add_bits(1'b0, per);
        for (int i = 0; i < 8; i++) add_bits(b[i], per);
        add_bits(1'b1, per);
    endtask

    task automatic check_wave(input string name, output int f);
        int mism = -1;
        f = -1;
        for (int i = 0; i < txq.size(); i++) begin
            if (txq[i] == 1'b0) begin
                f = i;
                break;
            end
        end
        total++;
        if (f < 0) begin
            bad++;
            $display("FAIL %s: no start bit seen, got line idle expected falling edge", name);
        end else if (txq.size() < f + exp_q.size()) begin
            bad++;
            $display("FAIL %s: got %0d samples expected %0d", name, txq.size() - f, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (txq[f + i] !== exp_q[i]) begin
                    mism = i;
                    break;
                end
            end
            if (mism >= 0) begin
                bad++;
                $display("FAIL %s: sample %0d got %b expected %b", name, mism, txq[f + mism], exp_q[mism]);
            end
        end
    endtask

    task automatic wait_fall(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!tx) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: got no start bit expected one within 40 cycles", name);
        end
    endtask

    initial begin
        int f;
        logic [15:0] v;
        logic [15:0] st;
        int zeros_ok;

        vecs[0]  = '{1'b0, 3'd1, 16'h0000, 2'b11, 16'h0002};
        vecs[1]  = '{1'b0, 3'd2, 16'h0000, 2'b00, 16'h0363};
        vecs[2]  = '{1'b0, 3'd3, 16'h0000, 2'b11, 16'h0000};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 16'h0000};
        vecs[4]  = '{1'b1, 3'd2, 16'h0000, 2'b11, 16'h0000};
        vecs[5]  = '{1'b0, 3'd2, 16'h0000, 2'b00, 16'h0001};
        vecs[6]  = '{1'b1, 3'd2, 16'hABCD, 2'b01, 16'h0000};
        vecs[7]  = '{1'b0, 3'd2, 16'h0000, 2'b11, 16'h00CD};
        vecs[8]  = '{1'b1, 3'd2, 16'h1200, 2'b10, 16'h0000};
        vecs[9]  = '{1'b0, 3'd2, 16'h0000, 2'b11, 16'h12CD};
        vecs[10] = '{1'b1, 3'd2, 16'hFFFF, 2'b00, 16'h0000};
        vecs[11] = '{1'b0, 3'd2, 16'h0000, 2'b11, 16'h12CD};
        vecs[12] = '{1'b1, 3'd3, 16'hFFFF, 2'b11, 16'h0000};
        vecs[13] = '{1'b0, 3'd3, 16'h0000, 2'b11, 16'h0001};
        vecs[14] = '{1'b1, 3'd3, 16'h0000, 2'b11, 16'h0000};
        vecs[15] = '{1'b0, 3'd3, 16'h0000, 2'b11, 16'h0000};
        vecs[16] = '{1'b1, 3'd6, 16'h00AA, 2'b11, 16'h0000};
        vecs[17] = '{1'b0, 3'd6, 16'h0000, 2'b11, 16'h0000};
        vecs[18] = '{1'b0, 3'd4, 16'h0000, 2'b11, 16'h0000};
        vecs[19] = '{1'b1, 3'd0, 16'h0077, 2'b10, 16'h0000};
        vecs[20] = '{1'b0, 3'd1, 16'h0000, 2'b11, 16'h0002};

        repeat (3) @(negedge clk);
        check16("reset_tx", {15'd0, tx}, 16'd1);
        check16("reset_ack", {15'd0, ack}, 16'd0);
        check16("reset_irq", {15'd0, irq}, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, v);
            check16($sformatf("vec%0d", i), v, vecs[i].exp);
        end

        // 0x55 at DIV=3, then idle
        wr(3'd2, 16'd3, 2'b11);
        txq.delete(); irqq.delete(); exp_q.delete();
        rec = 1'b1;
        wr(3'd0, 16'h0055, 2'b01);
        repeat (70) @(negedge clk);
        rec = 1'b0;
        add_frame(8'h55, 4);
        add_bits(1'b1, 8);
        check_wave("frame_55", f);
        rd_chk("idle_status", 3'd1, 16'h0002);

        // back-to-back frames with no idle gap
        txq.delete(); irqq.delete(); exp_q.delete();
        rec = 1'b1;
        wr(3'd0, 16'h00A5, 2'b01);
        wr(3'd0, 16'h003C, 2'b01);
        repeat (110) @(negedge clk);
        rec = 1'b0;
        add_frame(8'hA5, 4);
        add_frame(8'h3C, 4);
        add_bits(1'b1, 8);
        check_wave("back_to_back", f);

        // DIV change during data bit 0 applies from bit 1
        wr(3'd2, 16'h0000, 2'b11);
        rd_chk("div_zero", 3'd2, 16'h0001);
        wr(3'd2, 16'd7, 2'b11);
        txq.delete(); irqq.delete(); exp_q.delete();
        rec = 1'b1;
        wr(3'd0, 16'h0055, 2'b01);
        wait_fall("div_change_start");
        repeat (10) @(negedge clk);
        wr(3'd2, 16'd3, 2'b11);
        repeat (80) @(negedge clk);
        rec = 1'b0;
        add_bits(1'b0, 8);
        add_bits(1'b1, 8);
        for (int i = 1; i < 8; i++) add_bits(i[0] ? 1'b0 : 1'b1, 4);
        add_bits(1'b1, 4);
        add_bits(1'b1, 8);
        check_wave("div_change", f);
        rd_chk("div_new", 3'd2, 16'h0003);

        // interrupt: low while busy, high one cycle after return to idle
        wr(3'd3, 16'h0001, 2'b01);
        repeat (2) @(negedge clk);
        check16("irq_idle", {15'd0, irq}, 16'd1);
        txq.delete(); irqq.delete(); exp_q.delete();
        rec = 1'b1;
        wr(3'd0, 16'h0081, 2'b01);
        repeat (60) @(negedge clk);
        rec = 1'b0;
        add_frame(8'h81, 4);
        check_wave("frame_81", f);
        if (f >= 0 && irqq.size() > f + 41) begin
            zeros_ok = 1;
            for (int i = 0; i <= 40; i++) if (irqq[f + i] !== 1'b0) zeros_ok = 0;
            check16("irq_low_busy", zeros_ok[15:0], 16'd1);
            check16("irq_rise", {15'd0, irqq[f + 41]}, 16'd1);
        end else begin
            total++; bad++;
            $display("FAIL irq_trace: got %0d samples expected at least %0d", irqq.size(), f + 42);
        end
        wr(3'd3, 16'h0000, 2'b01);

        // overflow with a stalled transmitter
        wr(3'd2, 16'hFFFF, 2'b11);
        for (int i = 0; i < 17; i++) wr(3'd0, 16'(i), 2'b01);
        rd_chk("full_status", 3'd1, 16'h0105);
        wr(3'd0, 16'h00EE, 2'b01);
        rd_chk("ovf_status", 3'd1, 16'h010D);
        wr(3'd1, 16'h0008, 2'b10);
        rd_chk("ovf_hi_lane", 3'd1, 16'h010D);
        wr(3'd1, 16'h0008, 2'b01);
        rd_chk("ovf_clear", 3'd1, 16'h0105);

        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rd_chk("post_reset_status", 3'd1, 16'h0002);

        // reset in the middle of a data bit
        wr(3'd2, 16'd3, 2'b11);
        wr(3'd0, 16'h0055, 2'b01);
        wait_fall("mid_reset_start");
        repeat (9) @(negedge clk);
        check16("mid_bit1_low", {15'd0, tx}, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        check16("async_tx_high", {15'd0, tx}, 16'd1);
        check16("async_ack_low", {15'd0, ack}, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check16("tx_stays_idle", {15'd0, tx}, 16'd1);
        xfer(1'b0, 3'd1, 16'd0, 2'b11, st);
        check16("reset_status", st, 16'h0002);
        rd_chk("reset_div", 3'd2, 16'h0363);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
